// File: rtl/team_09_wbm_arbiter.sv
// rtl/team_09_wbm_arbiter.sv - round-robin two-requester Wishbone classic master with ACK timeout
module team_09_wbm_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk_i,
    input  logic        nrst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_adr,
    input  logic [31:0] r0_wdat,
    input  logic [3:0]  r0_sel,
    output logic        r0_done,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_adr,
    input  logic [31:0] r1_wdat,
    input  logic [3:0]  r1_sel,
    output logic        r1_done,
    output logic [31:0] rdat,
    output logic        err,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             gnt_id;
    logic             grant_sel;

    // On a tie the requester that did not finish last wins.
    always_comb begin
        grant_sel = 1'b0;
        if (r0_req && r1_req) begin
            grant_sel = ~last_grant;
        end else if (r1_req) begin
            grant_sel = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            ADR_O      <= '0;
            DAT_O      <= '0;
            SEL_O      <= '0;
            WE_O       <= 1'b0;
            STB_O      <= 1'b0;
            CYC_O      <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
            rdat       <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        ADR_O  <= grant_sel ? r1_adr  : r0_adr;
                        DAT_O  <= grant_sel ? r1_wdat : r0_wdat;
                        SEL_O  <= grant_sel ? r1_sel  : r0_sel;
                        WE_O   <= grant_sel ? r1_we   : r0_we;
                        CYC_O  <= 1'b1;
                        STB_O  <= 1'b1;
                        cnt    <= '0;
                        gnt_id <= grant_sel;
                        state  <= BUS;
                    end
                end
                BUS: begin
                    // ACK wins over a timeout landing on the same edge.
                    if (ACK_I) begin
                        CYC_O      <= 1'b0;
                        STB_O      <= 1'b0;
                        rdat       <= WE_O ? 32'h0 : DAT_I;
                        err        <= 1'b0;
                        r0_done    <= ~gnt_id;
                        r1_done    <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        CYC_O      <= 1'b0;
                        STB_O      <= 1'b0;
                        rdat       <= 32'h0;
                        err        <= 1'b1;
                        r0_done    <= ~gnt_id;
                        r1_done    <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    r0_done <= 1'b0;
                    r1_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_team_09_wbm_arbiter.sv
// tb/tb_team_09_wbm_arbiter.sv - directed scoreboard bench for team_09_wbm_arbiter
module tb_team_09_wbm_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        nrst = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0, r0_done;
    logic [31:0] r0_adr = '0, r0_wdat = '0;
    logic [3:0]  r0_sel = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0, r1_done;
    logic [31:0] r1_adr = '0, r1_wdat = '0;
    logic [3:0]  r1_sel = '0;
    logic [31:0] rdat;
    logic        err;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O, STB_O, CYC_O;
    logic [31:0] DAT_I = '0;
    logic        ACK_I = 1'b0;

    int total = 0, bad = 0;
    int done_cnt = 0, cyc = 0, stb_cnt = 0, last_len = 0, ack_cyc = 0;
    int ack_delay = 0;
    int t0;
    logic spur_ack = 1'b0;

    typedef struct {
        logic        id;
        logic [31:0] rdat;
        logic        err;
    } exp_t;
    exp_t sb[$];

    team_09_wbm_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk_i(clk_i), .nrst(nrst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_wdat(r0_wdat),
        .r0_sel(r0_sel), .r0_done(r0_done),
        .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_wdat(r1_wdat),
        .r1_sel(r1_sel), .r1_done(r1_done),
        .rdat(rdat), .err(err),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic id, input logic [31:0] d, input logic e);
        exp_t x;
        x.id = id;
        x.rdat = d;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_done(input int target, input int max);
        int n = 0;
        while (done_cnt < target && n < max) begin
            step();
            n++;
        end
        chk("done_wait", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_stb(input int max);
        int n = 0;
        while (!STB_O && n < max) begin
            step();
            n++;
        end
        chk("stb_wait", 32'(STB_O), 32'd1);
    endtask

    // Slave model: acks once STB has been seen for more than ack_delay cycles.
    initial begin
        forever begin
            @(negedge clk_i);
            if (STB_O) begin
                stb_cnt = stb_cnt + 1;
            end else begin
                if (stb_cnt != 0) last_len = stb_cnt;
                stb_cnt = 0;
            end
            ACK_I = spur_ack || (STB_O && stb_cnt > ack_delay);
            if (ACK_I) ack_cyc = cyc;
        end
    end

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (r0_done || r1_done) begin
                done_cnt++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                chk("done_excl", 32'(r0_done & r1_done), 32'd0);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_id", 32'(r1_done), 32'(e.id));
                    chk("done_rdat", rdat, e.rdat);
                    chk("done_err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        step();
        chk("rst_cyc", 32'(CYC_O), 0);
        chk("rst_stb", 32'(STB_O), 0);
        chk("rst_adr", ADR_O, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_sel", 32'(SEL_O), 0);
        chk("rst_we", 32'(WE_O), 0);
        chk("rst_done", 32'({r0_done, r1_done}), 0);
        chk("rst_rdat", rdat, 0);
        chk("rst_err", 32'(err), 0);
        nrst = 1'b1;
        step();

        // r0 read, ACK two cycles after STB
        DAT_I = 32'hDEADBEEF; ack_delay = 2;
        r0_adr = 32'h3000_0010; r0_we = 1'b0; r0_sel = 4'hF;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        r0_req = 1'b1;
        wait_stb(10);
        chk("t1_adr", ADR_O, 32'h3000_0010);
        chk("t1_we", 32'(WE_O), 0);
        chk("t1_cyc", 32'(CYC_O), 1);
        wait_done(1, 20);
        chk("t1_ack_to_done", 32'(cyc - ack_cyc), 1);
        r0_req = 1'b0;
        chk("t1_stb_len", 32'(last_len), 3);
        step();
        chk("t1_done_width", 32'(r0_done), 0);

        // r1 write, immediate ACK
        DAT_I = 32'h1111_1111; ack_delay = 0;
        r1_adr = 32'h3000_0004; r1_wdat = 32'h0000_00A5; r1_sel = 4'b0001; r1_we = 1'b1;
        push(1'b1, 32'h0, 1'b0);
        r1_req = 1'b1;
        wait_stb(10);
        chk("t2_adr", ADR_O, 32'h3000_0004);
        chk("t2_dat", DAT_O, 32'h0000_00A5);
        chk("t2_sel", 32'(SEL_O), 1);
        chk("t2_we", 32'(WE_O), 1);
        wait_done(2, 20);
        r1_req = 1'b0;
        chk("t2_stb_len", 32'(last_len), 1);

        // fairness after reset: both requesting continuously
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        r0_adr = 32'h0000_0100; r0_we = 1'b0;
        r1_adr = 32'h0000_0200; r1_we = 1'b0;
        DAT_I = 32'h5555_AAAA; ack_delay = 0;
        push(1'b0, 32'h5555_AAAA, 1'b0);
        push(1'b1, 32'h5555_AAAA, 1'b0);
        push(1'b0, 32'h5555_AAAA, 1'b0);
        push(1'b1, 32'h5555_AAAA, 1'b0);
        r0_req = 1'b1; r1_req = 1'b1;
        wait_done(3, 20);
        t0 = cyc;
        wait_done(6, 40);
        chk("t3_period", 32'(cyc - t0), 9);
        r0_req = 1'b0; r1_req = 1'b0;
        step();

        // timeout with no ACK, then a normal request
        ack_delay = 1000; DAT_I = 32'h1234_5678;
        r0_adr = 32'h3000_0020; r0_we = 1'b0;
        push(1'b0, 32'h0, 1'b1);
        r0_req = 1'b1;
        wait_done(7, 30);
        r0_req = 1'b0;
        chk("t4_stb_len", 32'(last_len), TO);
        step();
        ack_delay = 1; DAT_I = 32'h0BAD_F00D;
        r1_adr = 32'h3000_0024; r1_we = 1'b0;
        push(1'b1, 32'h0BAD_F00D, 1'b0);
        r1_req = 1'b1;
        wait_done(8, 20);
        r1_req = 1'b0;
        chk("t4_next_len", 32'(last_len), 2);
        step();

        // ACK on the same edge the counter hits its last value
        ack_delay = TO - 1; DAT_I = 32'hCAFE_F00D;
        push(1'b0, 32'hCAFE_F00D, 1'b0);
        r0_req = 1'b1;
        wait_done(9, 20);
        r0_req = 1'b0;
        chk("t5_stb_len", 32'(last_len), TO);
        step();

        // reset mid-BUS: no done, then r0 wins the tie
        ack_delay = 1000;
        r1_adr = 32'h3000_0040;
        r1_req = 1'b1;
        wait_stb(10);
        step();
        nrst = 1'b0; r1_req = 1'b0;
        step();
        chk("t6_cyc", 32'(CYC_O), 0);
        chk("t6_stb", 32'(STB_O), 0);
        nrst = 1'b1;
        step();
        step();
        chk("t6_no_done", 32'(done_cnt), 9);
        ack_delay = 0; DAT_I = 32'h7777_8888;
        push(1'b0, 32'h7777_8888, 1'b0);
        push(1'b1, 32'h7777_8888, 1'b0);
        r0_req = 1'b1; r1_req = 1'b1;
        wait_done(11, 20);
        r0_req = 1'b0; r1_req = 1'b0;
        step();

        // spurious ACK while idle
        DAT_I = 32'hFFFF_0000;
        spur_ack = 1'b1;
        step();
        spur_ack = 1'b0;
        step();
        step();
        chk("t7_rdat", rdat, 32'h7777_8888);
        chk("t7_cyc", 32'(CYC_O), 0);
        chk("t7_stb", 32'(STB_O), 0);
        chk("t7_no_done", 32'(done_cnt), 11);
        DAT_I = 32'h2468_1357;
        push(1'b0, 32'h2468_1357, 1'b0);
        r0_req = 1'b1;
        wait_done(12, 20);
        r0_req = 1'b0;
        step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
